// File: rtl/abs_diff_ctl_pkg.sv
// rtl/abs_diff_ctl_pkg.sv - shared state encoding and width helpers for the abs-diff sweep controller
package abs_diff_ctl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Bits needed to hold values 0..n, never less than one.
   function automatic int unsigned bits_for(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/abs_diff_err_eval.sv
// rtl/abs_diff_err_eval.sv - combinational error of one approximate result against exact |a-b|
module abs_diff_err_eval #(
   parameter int unsigned W  = 2,
   parameter int unsigned OW = 3,
   parameter int unsigned ET = 4
) (
   input  logic [W-1:0]  i_a,
   input  logic [W-1:0]  i_b,
   input  logic [OW-1:0] i_approx,
   output logic [OW-1:0] o_err,
   output logic          o_viol
);

   logic [W-1:0]  w_diff;
   logic [OW:0]   w_exact;
   logic [OW:0]   w_approx;
   logic [OW:0]   w_err_full;

   assign w_diff     = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
   assign w_exact    = {1'b0, OW'(w_diff)};
   assign w_approx   = {1'b0, i_approx};
   // Both operands are below 2^OW, so the magnitude always fits back into OW bits.
   assign w_err_full = (w_approx >= w_exact) ? (w_approx - w_exact) : (w_exact - w_approx);
   assign o_err      = w_err_full[OW-1:0];
   assign o_viol     = (32'(o_err) > ET);

endmodule

// File: rtl/abs_diff_sweep_ctl.sv
// rtl/abs_diff_sweep_ctl.sv - exhaustive sweep of an approximate abs-diff core with error statistics
module abs_diff_sweep_ctl
   import abs_diff_ctl_pkg::*;
#(
   parameter int unsigned W      = 2,
   parameter int unsigned OW     = 3,
   parameter int unsigned ET     = 4,
   parameter int unsigned SETTLE = 0,
   parameter int unsigned SUMW   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [2*W-1:0]    vec_o,
   input  logic [OW-1:0]     approx_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [OW-1:0]     max_err_o,
   output logic [SUMW-1:0]   sum_err_o,
   output logic [2*W:0]      viol_cnt_o,
   output logic [2*W-1:0]    first_viol_o,
   output logic              first_vld_o
);

   localparam int unsigned   VW        = 2 * W;
   localparam int unsigned   HW        = bits_for(SETTLE);
   localparam logic [HW-1:0] HOLD_LAST = HW'(SETTLE);
   localparam logic [VW-1:0] VEC_LAST  = '1;

   state_t          r_state, w_state_nxt;
   logic            w_clear, w_sample;
   logic [VW-1:0]   r_vec;
   logic [HW-1:0]   r_hold;
   logic            r_ev_vld;
   logic [VW-1:0]   r_ev_vec;
   logic [OW-1:0]   r_ev_approx;
   logic [OW-1:0]   r_max;
   logic [SUMW-1:0] r_sum;
   logic [VW:0]     r_viol_cnt;
   logic [VW-1:0]   r_first;
   logic            r_first_vld;
   logic            r_pass;
   logic [OW-1:0]   w_err;
   logic            w_viol;
   logic [OW-1:0]   w_max_nxt;
   logic [SUMW:0]   w_sum_wide;
   logic [SUMW-1:0] w_sum_nxt;

   abs_diff_err_eval #(.W(W), .OW(OW), .ET(ET)) u_eval (
      .i_a      (r_ev_vec[W-1:0]),
      .i_b      (r_ev_vec[VW-1:W]),
      .i_approx (r_ev_approx),
      .o_err    (w_err),
      .o_viol   (w_viol)
   );

   assign w_max_nxt  = (w_err > r_max) ? w_err : r_max;
   assign w_sum_wide = {1'b0, r_sum} + (SUMW+1)'(w_err);
   assign w_sum_nxt  = w_sum_wide[SUMW] ? '1 : w_sum_wide[SUMW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_sample    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = S_DRIVE;
               w_clear     = 1'b1;
            end
         end
         S_DRIVE: begin
            if (r_hold == HOLD_LAST) begin
               w_sample = 1'b1;
               if (r_vec == VEC_LAST) w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      // Abort overrides every transition, including a start seen in the same cycle.
      if (abort_i) begin
         w_state_nxt = S_IDLE;
         w_clear     = 1'b0;
         w_sample    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec       <= '0;
         r_hold      <= '0;
         r_ev_vld    <= 1'b0;
         r_ev_vec    <= '0;
         r_ev_approx <= '0;
         r_max       <= '0;
         r_sum       <= '0;
         r_viol_cnt  <= '0;
         r_first     <= '0;
         r_first_vld <= 1'b0;
         r_pass      <= 1'b0;
      end else if (abort_i) begin
         r_vec    <= '0;
         r_hold   <= '0;
         r_ev_vld <= 1'b0;
      end else if (w_clear) begin
         r_vec       <= '0;
         r_hold      <= '0;
         r_ev_vld    <= 1'b0;
         r_max       <= '0;
         r_sum       <= '0;
         r_viol_cnt  <= '0;
         r_first     <= '0;
         r_first_vld <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_ev_vld <= w_sample;
         if (w_sample) begin
            r_ev_vec    <= r_vec;
            r_ev_approx <= approx_i;
            r_hold      <= '0;
            if (r_vec != VEC_LAST) r_vec <= r_vec + VW'(1);
         end else if (r_state == S_DRIVE) begin
            r_hold <= r_hold + HW'(1);
         end
         if (r_ev_vld) begin
            r_max <= w_max_nxt;
            r_sum <= w_sum_nxt;
            if (w_viol) begin
               r_viol_cnt <= r_viol_cnt + (VW+1)'(1);
               if (!r_first_vld) begin
                  r_first     <= r_ev_vec;
                  r_first_vld <= 1'b1;
               end
            end
         end
         // The last vector retires during DRAIN, so pass uses the post-retire maximum.
         if (r_state == S_DRAIN) r_pass <= (32'(w_max_nxt) <= ET);
      end
   end

   assign vec_o        = r_vec;
   assign busy_o       = (r_state != S_IDLE);
   assign done_o       = (r_state == S_DONE);
   assign pass_o       = r_pass;
   assign max_err_o    = r_max;
   assign sum_err_o    = r_sum;
   assign viol_cnt_o   = r_viol_cnt;
   assign first_viol_o = r_first;
   assign first_vld_o  = r_first_vld;

endmodule

// File: tb/tb_abs_diff_sweep_ctl.sv
// tb/tb_abs_diff_sweep_ctl.sv - directed bench for the abs-diff sweep controller
module tb_abs_diff_sweep_ctl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] st = '0;
   logic       ab0 = 1'b0;
   logic       ab_off = 1'b0;
   int         mode0 = 0, mode1 = 0, mode2 = 0;

   wire [2:0]  busy, dn, pass, fvld;
   wire [3:0]  vec0, vec1, vec2, fv0, fv1, fv2;
   wire [2:0]  max0, max1, max2;
   wire [15:0] sum0, sum2;
   wire [5:0]  sum1;
   wire [4:0]  vc0, vc1, vc2;
   logic [2:0] ap0, ap1, ap2;

   int checks = 0;
   int errors = 0;
   int lat;
   int pulses;
   bit seq_ok;

   // Core stand-in: 0 = exact |a-b|, 1 = tied 0, 2 = tied 7.
   function automatic logic [2:0] model(input int m, input logic [3:0] v);
      logic [1:0] a, b;
      a = v[1:0];
      b = v[3:2];
      case (m)
         0:       return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
         1:       return 3'd0;
         default: return 3'd7;
      endcase
   endfunction

   assign ap0 = model(mode0, vec0);
   assign ap1 = model(mode1, vec1);
   assign ap2 = model(mode2, vec2);

   abs_diff_sweep_ctl dut0 (
      .clk(clk), .rst_n(rst_n), .start_i(st[0]), .abort_i(ab0), .vec_o(vec0), .approx_i(ap0),
      .busy_o(busy[0]), .done_o(dn[0]), .pass_o(pass[0]), .max_err_o(max0), .sum_err_o(sum0),
      .viol_cnt_o(vc0), .first_viol_o(fv0), .first_vld_o(fvld[0])
   );

   abs_diff_sweep_ctl #(.ET(2), .SUMW(6)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(st[1]), .abort_i(ab_off), .vec_o(vec1), .approx_i(ap1),
      .busy_o(busy[1]), .done_o(dn[1]), .pass_o(pass[1]), .max_err_o(max1), .sum_err_o(sum1),
      .viol_cnt_o(vc1), .first_viol_o(fv1), .first_vld_o(fvld[1])
   );

   abs_diff_sweep_ctl #(.SETTLE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start_i(st[2]), .abort_i(ab_off), .vec_o(vec2), .approx_i(ap2),
      .busy_o(busy[2]), .done_o(dn[2]), .pass_o(pass[2]), .max_err_o(max2), .sum_err_o(sum2),
      .viol_cnt_o(vc2), .first_viol_o(fv2), .first_vld_o(fvld[2])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Start cycle is cycle 0; returns at the negedge of cycle 1.
   task automatic run_start(input int idx);
      @(negedge clk);
      st[idx] = 1'b1;
      @(negedge clk);
      st[idx] = 1'b0;
   endtask

   task automatic wait_done(input int idx, input int base, output int cyc);
      cyc = base;
      while (!dn[idx] && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      if (!dn[idx]) cyc = -1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(dn), 0);
      chk("reset pass", 32'(pass), 0);
      chk("reset vec", 32'({vec0, vec1, vec2}), 0);
      chk("reset results", 32'({max0, vc0, fv0, fvld}), 0);
      rst_n = 1'b1;

      // 1: exact core
      mode0 = 0;
      run_start(0);
      chk("t1 busy", 32'(busy[0]), 1);
      wait_done(0, 1, lat);
      chk("t1 latency", lat, 18);
      @(negedge clk);
      chk("t1 single pulse", 32'({dn[0], busy[0]}), 0);
      chk("t1 max", 32'(max0), 0);
      chk("t1 sum", 32'(sum0), 0);
      chk("t1 viol", 32'(vc0), 0);
      chk("t1 pass", 32'(pass[0]), 1);

      // 2: tied 0, ET=4 and ET=2
      mode0 = 1;
      mode1 = 1;
      run_start(0);
      wait_done(0, 1, lat);
      @(negedge clk);
      chk("t2 max", 32'(max0), 3);
      chk("t2 sum", 32'(sum0), 20);
      chk("t2 viol", 32'(vc0), 0);
      chk("t2 pass", 32'(pass[0]), 1);
      run_start(1);
      wait_done(1, 1, lat);
      chk("t2b latency", lat, 18);
      @(negedge clk);
      chk("t2b viol", 32'(vc1), 2);
      chk("t2b pass", 32'(pass[1]), 0);
      chk("t2b first", 32'(fv1), 3);
      chk("t2b first vld", 32'(fvld[1]), 1);
      chk("t2b sum", 32'(sum1), 20);

      // 3: tied 7; narrow accumulator on dut1 saturates
      mode0 = 2;
      mode1 = 2;
      run_start(0);
      wait_done(0, 1, lat);
      @(negedge clk);
      chk("t3 max", 32'(max0), 7);
      chk("t3 sum", 32'(sum0), 92);
      chk("t3 viol", 32'(vc0), 14);
      chk("t3 first", 32'(fv0), 0);
      chk("t3 first vld", 32'(fvld[0]), 1);
      chk("t3 pass", 32'(pass[0]), 0);
      run_start(1);
      wait_done(1, 1, lat);
      @(negedge clk);
      chk("t3b sum sat", 32'(sum1), 63);
      chk("t3b viol all", 32'(vc1), 16);

      // 4: SETTLE=2
      mode2 = 0;
      run_start(2);
      for (int k = 1; k <= 6; k++) begin
         chk("t4 hold vec", 32'(vec2), (k - 1) / 3);
         @(negedge clk);
      end
      wait_done(2, 7, lat);
      chk("t4 latency", lat, 50);
      @(negedge clk);
      chk("t4 pass", 32'(pass[2]), 1);

      // 5: abort vs start in IDLE, then abort mid-sweep
      mode0 = 0;
      @(negedge clk);
      st[0] = 1'b1;
      ab0 = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      ab0 = 1'b0;
      chk("t5 abort beats start", 32'(busy[0]), 0);
      run_start(0);
      repeat (5) @(negedge clk);
      ab0 = 1'b1;
      @(negedge clk);
      ab0 = 1'b0;
      chk("t5 abort busy", 32'(busy[0]), 0);
      chk("t5 abort vec", 32'(vec0), 0);
      pulses = 0;
      repeat (25) begin
         @(negedge clk);
         if (dn[0]) pulses++;
      end
      chk("t5 no done", pulses, 0);
      run_start(0);
      wait_done(0, 1, lat);
      chk("t5 rerun latency", lat, 18);
      @(negedge clk);
      chk("t5 rerun sum", 32'(sum0), 0);
      chk("t5 rerun pass", 32'(pass[0]), 1);

      // 6: start while busy ignored
      run_start(0);
      seq_ok = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (vec0 !== 4'(k - 1)) seq_ok = 1'b0;
         if (k == 3) st[0] = 1'b1;
         if (k == 5) st[0] = 1'b0;
         @(negedge clk);
      end
      chk("t6 vec sequence", 32'(seq_ok), 1);
      wait_done(0, 17, lat);
      chk("t6 latency", lat, 18);
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (dn[0]) pulses++;
      end
      chk("t6 single done", pulses, 0);

      // 6: async reset mid-sweep
      mode0 = 2;
      run_start(0);
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6 rst busy", 32'(busy[0]), 0);
      chk("t6 rst vec", 32'(vec0), 0);
      chk("t6 rst results", 32'({max0, sum0, vc0, fvld[0]}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (25) begin
         @(negedge clk);
         if (dn[0]) pulses++;
      end
      chk("t6 rst no done", pulses, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
